// File: rtl/sd_sched_pkg.sv
// Shared definitions for the SD buffer-descriptor scheduler.
// Contents:
//   state_e        - scheduler FSM states
//   ERR_*          - error codes reported on err_code_o
//   SEL_TX/SEL_RX  - queue select encoding (TX = 1 so that dat_dir_o = sel)
//   BD_WORD_*      - word offsets inside a 2-word buffer descriptor
package sd_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_ADDR = 4'd1,
    ST_FETCH_ARG  = 4'd2,
    ST_CMD        = 4'd3,
    ST_CMD_WAIT   = 4'd4,
    ST_DAT        = 4'd5,
    ST_DAT_WAIT   = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERR        = 4'd8
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CMD  = 2'b01;
  localparam logic [1:0] ERR_DAT  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  // word0 carries the system memory address, word1 the card block argument
  localparam logic BD_WORD_ADDR = 1'b0;
  localparam logic BD_WORD_ARG  = 1'b1;

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin arbiter between the TX and RX BD queues.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   req_tx_i/rx_i   - queue non-empty requests
//   upd_i           - record upd_sel_i as the last serviced queue
//   upd_sel_i       - queue that was just serviced
//   gnt_valid_o     - at least one request present
//   gnt_sel_o       - granted queue (SEL_TX / SEL_RX)
module sd_rr_arb2
  import sd_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_tx_i,
  input  logic req_rx_i,
  input  logic upd_i,
  input  logic upd_sel_i,
  output logic gnt_valid_o,
  output logic gnt_sel_o
);

  logic last_q;

  // Last-grant register; resets to RX so TX wins the very first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= SEL_RX;
    end else if (upd_i) begin
      last_q <= upd_sel_i;
    end
  end

  // On a tie the queue that was not serviced last wins.
  always_comb begin
    gnt_valid_o = req_tx_i | req_rx_i;
    if (req_tx_i && req_rx_i) begin
      gnt_sel_o = ~last_q;
    end else if (req_tx_i) begin
      gnt_sel_o = SEL_TX;
    end else begin
      gnt_sel_o = SEL_RX;
    end
  end

endmodule

// File: rtl/sd_bd_scheduler.sv
// Buffer-descriptor scheduler for the SD controller.
// Pops one 2-word BD from the TX or RX queue (round-robin), issues the
// matching block command to the command master, then starts the data
// engine and reports completion or error.
// Ports:
//   wb_clk_i, wb_rst_i          - clock, asynchronous active-low reset
//   enable_i, abort_i           - start permission, software abort
//   timeout_i                   - wait limit in cycles (0 = no timeout)
//   tx_*/rx_*                   - first-word-fall-through BD FIFO interfaces
//   cmd_*                       - command master handshake
//   dat_*                       - data engine / DMA handshake
//   busy_o, tx_done_o, rx_done_o, err_o, err_code_o, halted_o - status
module sd_bd_scheduler
  import sd_sched_pkg::*;
#(
  parameter logic [5:0] CMD_WR = 6'd24,
  parameter logic [5:0] CMD_RD = 6'd17,
  parameter int         TO_W   = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            enable_i,
  input  logic            abort_i,
  input  logic [TO_W-1:0] timeout_i,
  input  logic            tx_empty_i,
  input  logic [31:0]     tx_dat_i,
  output logic            tx_re_o,
  input  logic            rx_empty_i,
  input  logic [31:0]     rx_dat_i,
  output logic            rx_re_o,
  output logic            cmd_start_o,
  output logic [5:0]      cmd_index_o,
  output logic [31:0]     cmd_arg_o,
  input  logic            cmd_done_i,
  input  logic            cmd_err_i,
  output logic            dat_start_o,
  output logic            dat_dir_o,
  output logic [31:0]     dat_addr_o,
  input  logic            dat_done_i,
  input  logic            dat_err_i,
  output logic            busy_o,
  output logic            tx_done_o,
  output logic            rx_done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic            halted_o
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       arg_q, arg_d;
  logic [5:0]        idx_q, idx_d;
  logic [1:0]        code_q, code_d;
  logic              halted_q, halted_d;

  logic              gnt_valid, gnt_sel;
  logic              head_empty, pop, fetch_word, to_hit, arb_upd;
  logic [31:0]       head_dat;

  sd_rr_arb2 u_arb (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_i),
    .req_tx_i    (!tx_empty_i),
    .req_rx_i    (!rx_empty_i),
    .upd_i       (arb_upd),
    .upd_sel_i   (sel_q),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel)
  );

  // Fetch datapath: pop the selected queue whenever it has a word; an abort
  // leaves the FIFO untouched.
  always_comb begin
    head_empty = (sel_q == SEL_TX) ? tx_empty_i : rx_empty_i;
    head_dat   = (sel_q == SEL_TX) ? tx_dat_i : rx_dat_i;
    fetch_word = (state_q == ST_FETCH_ARG) ? BD_WORD_ARG : BD_WORD_ADDR;
    pop        = ((state_q == ST_FETCH_ADDR) || (state_q == ST_FETCH_ARG))
                 && !head_empty && !abort_i;
    to_hit     = (timeout_i != '0) && (cnt_q == timeout_i - TO_W'(1));
    arb_upd    = ((state_q == ST_DONE) || (state_q == ST_ERR)) && !abort_i;
  end

  // Next-state logic; abort overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    arg_d    = arg_q;
    idx_d    = idx_q;
    code_d   = code_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && !halted_q && gnt_valid) begin
          sel_d   = gnt_sel;
          idx_d   = (gnt_sel == SEL_TX) ? CMD_WR : CMD_RD;
          state_d = ST_FETCH_ADDR;
        end
      end
      ST_FETCH_ADDR, ST_FETCH_ARG: begin
        if (pop) begin
          if (fetch_word == BD_WORD_ADDR) begin
            addr_d  = head_dat;
            state_d = ST_FETCH_ARG;
          end else begin
            arg_d   = head_dat;
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        cnt_d   = '0;
        state_d = ST_CMD_WAIT;
      end
      ST_CMD_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // a done in the timeout cycle takes precedence
        if (cmd_done_i) begin
          if (cmd_err_i) begin
            state_d  = ST_ERR;
            code_d   = ERR_CMD;
            halted_d = 1'b1;
          end else begin
            state_d = ST_DAT;
          end
        end else if (to_hit) begin
          state_d  = ST_ERR;
          code_d   = ERR_TO;
          halted_d = 1'b1;
        end
      end
      ST_DAT: begin
        cnt_d   = '0;
        state_d = ST_DAT_WAIT;
      end
      ST_DAT_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dat_done_i) begin
          if (dat_err_i) begin
            state_d  = ST_ERR;
            code_d   = ERR_DAT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (to_hit) begin
          state_d  = ST_ERR;
          code_d   = ERR_TO;
          halted_d = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_i) begin
      state_d  = ST_IDLE;
      halted_d = 1'b0;
      code_d   = ERR_NONE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_RX;
      cnt_q    <= '0;
      addr_q   <= '0;
      arg_q    <= '0;
      idx_q    <= '0;
      code_q   <= ERR_NONE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      arg_q    <= arg_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      halted_q <= halted_d;
    end
  end

  // Outputs are decoded from state; completion pulses are masked by abort.
  always_comb begin
    tx_re_o     = pop && (sel_q == SEL_TX);
    rx_re_o     = pop && (sel_q == SEL_RX);
    cmd_start_o = (state_q == ST_CMD);
    dat_start_o = (state_q == ST_DAT);
    dat_dir_o   = ((state_q == ST_DAT) || (state_q == ST_DAT_WAIT)) && (sel_q == SEL_TX);
    busy_o      = (state_q != ST_IDLE);
    tx_done_o   = (state_q == ST_DONE) && (sel_q == SEL_TX) && !abort_i;
    rx_done_o   = (state_q == ST_DONE) && (sel_q == SEL_RX) && !abort_i;
    err_o       = (state_q == ST_ERR) && !abort_i;
    cmd_index_o = idx_q;
    cmd_arg_o   = arg_q;
    dat_addr_o  = addr_q;
    err_code_o  = code_q;
    halted_o    = halted_q;
  end

endmodule
